// File: rtl/inst_rom_loader_pkg.sv
// Shared constants and state encoding for the instruction ROM loader.
// Optional feature macro: INST_ROM_CHECKSUM_EN (adds ld_csum output).
package inst_rom_loader_pkg;

    localparam int          ADDR_W_DEF = 10;
    localparam int          DATA_W_DEF = 32;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b1;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// Packs accepted load bytes into 32-bit big-endian words, zero-padding a short final word.
// Optional feature macro: INST_ROM_CHECKSUM_EN (not used here).
module byte_packer
    import inst_rom_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic [DATA_W-1:0] word,
    output logic              word_vld
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift_q;

    // The incoming byte lands in its final lane directly, so a word is
    // available on the same edge that accepts its last byte.
    always_comb begin
        word = NOP_WORD;
        unique case (byte_cnt)
            2'd0: word = {ld_byte, 24'h0};
            2'd1: word = {shift_q[7:0], ld_byte, 16'h0};
            2'd2: word = {shift_q[15:0], ld_byte, 8'h0};
            2'd3: word = {shift_q[23:0], ld_byte};
        endcase
    end

    assign word_vld = accept && ((byte_cnt == 2'd3) || ld_last);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            byte_cnt <= 2'd0;
            shift_q  <= 24'h0;
        end else if (accept) begin
            if (word_vld) begin
                byte_cnt <= 2'd0;
                shift_q  <= 24'h0;
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
                shift_q  <= {shift_q[15:0], ld_byte};
            end
        end
    end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM for the openmips fetch port, filled from a byte-serial image after reset.
// Optional feature macro: INST_ROM_CHECKSUM_EN (adds the ld_csum running word sum).
//
// Load handshake: a byte transfers on a rising clk edge where ld_valid && ld_ready;
// ld_byte and ld_last must be held stable while ld_valid is high and not yet accepted.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [31:0]       addr,
    output logic [DATA_W-1:0] inst,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              core_rst,
    output logic              ld_done,
    output logic              ld_err,
    output state_t            state_dbg,
    output logic [ADDR_W:0]   ld_words
`ifdef INST_ROM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] ld_csum
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state, state_nxt;
    logic              accept;
    logic [DATA_W-1:0] word;
    logic              word_vld;
    logic              mem_we;
    logic [ADDR_W:0]   wr_ptr;
    logic              fetch_hit;
    logic [DATA_W-1:0] mem [DEPTH];

    assign accept = ld_valid && ld_ready;

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .ld_byte  (ld_byte),
        .ld_last  (ld_last),
        .word     (word),
        .word_vld (word_vld)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) state <= LOAD;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        core_rst  = 1'b0;
        ld_done   = 1'b0;
        unique case (state)
            LOAD: begin
                ld_ready = 1'b1;
                core_rst = 1'b1;
                if (accept && ld_last) state_nxt = RUN;
            end
            RUN: ld_done = 1'b1;
        endcase
    end

    assign state_dbg = state;

    // wr_ptr carries one extra bit so that reaching DEPTH marks the array full.
    assign mem_we   = word_vld && !wr_ptr[ADDR_W];
    assign ld_words = wr_ptr;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wr_ptr <= '0;
            ld_err <= 1'b0;
        end else if (word_vld) begin
            if (mem_we) wr_ptr <= wr_ptr + 1'b1;
            else        ld_err <= 1'b1;
        end
    end

    // Contents survive reset so a reload only overwrites the words it covers.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= word;
    end

    assign fetch_hit = ce && (state == RUN) && (addr[1:0] == 2'b00)
                       && (addr[31:ADDR_W+2] == '0);
    assign inst      = fetch_hit ? mem[addr[ADDR_W+1:2]] : NOP_WORD;

`ifdef INST_ROM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) ld_csum <= '0;
        else if (mem_we)       ld_csum <= ld_csum + word;
    end
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: a default-depth instance and a 4-word instance for overflow.
// Optional feature macro: INST_ROM_CHECKSUM_EN (enables the ld_csum checks).
module tb_inst_rom_loader;
    import inst_rom_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [7:0]  ld_byte = 8'h0;
    logic        ld_last = 1'b0;
    logic        ld_valid_a = 1'b0, ld_valid_b = 1'b0;

    logic [31:0] inst_a, inst_b;
    logic        ld_ready_a, core_rst_a, ld_done_a, ld_err_a;
    logic        ld_ready_b, core_rst_b, ld_done_b, ld_err_b;
    state_t      state_a, state_b;
    logic [10:0] ld_words_a;
    logic [2:0]  ld_words_b;
`ifdef INST_ROM_CHECKSUM_EN
    logic [31:0] ld_csum_a, ld_csum_b;
`endif

    inst_rom_loader #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_a),
        .ld_valid(ld_valid_a), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready_a), .core_rst(core_rst_a), .ld_done(ld_done_a),
        .ld_err(ld_err_a), .state_dbg(state_a), .ld_words(ld_words_a)
`ifdef INST_ROM_CHECKSUM_EN
        , .ld_csum(ld_csum_a)
`endif
    );

    inst_rom_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
        .ld_valid(ld_valid_b), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready_b), .core_rst(core_rst_b), .ld_done(ld_done_b),
        .ld_err(ld_err_b), .state_dbg(state_b), .ld_words(ld_words_b)
`ifdef INST_ROM_CHECKSUM_EN
        , .ld_csum(ld_csum_b)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: expected values queued by the driver, popped by the monitor.
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          chk_sel = 0;
    logic        chk_valid = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    localparam int S_INST_A = 0, S_WORDS_A = 1, S_DONE_A = 2, S_CRST_A = 3,
                   S_ERR_A = 4, S_READY_A = 5, S_INST_B = 6, S_WORDS_B = 7,
                   S_ERR_B = 8, S_DONE_B = 9, S_CSUM_A = 10, S_STATE_A = 11;

    always @(negedge clk) begin
        if (chk_valid) begin
            logic [31:0] act;
            logic [31:0] exp;
            string       nm;
            act = 32'h0;
            case (chk_sel)
                S_INST_A:  act = inst_a;
                S_WORDS_A: act = {21'h0, ld_words_a};
                S_DONE_A:  act = {31'h0, ld_done_a};
                S_CRST_A:  act = {31'h0, core_rst_a};
                S_ERR_A:   act = {31'h0, ld_err_a};
                S_READY_A: act = {31'h0, ld_ready_a};
                S_INST_B:  act = inst_b;
                S_WORDS_B: act = {29'h0, ld_words_b};
                S_ERR_B:   act = {31'h0, ld_err_b};
                S_DONE_B:  act = {31'h0, ld_done_b};
`ifdef INST_ROM_CHECKSUM_EN
                S_CSUM_A:  act = ld_csum_a;
`endif
                S_STATE_A: act = {31'h0, state_a};
                default:   act = 32'hxxxx_xxxx;
            endcase
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output: actual=%h required=<none queued>", act);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act === exp) n_pass = n_pass + 1;
                else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        chk_sel   = sel;
        chk_valid = 1'b1;
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic fetch(input int sel, input logic f_ce, input logic [31:0] f_addr,
                         input logic [31:0] exp, input string name);
        ce   = f_ce;
        addr = f_addr;
        chk(sel, exp, name);
        ce   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input bit to_b, input logic [7:0] b, input logic last);
        int budget;
        budget = 0;
        ld_byte = b;
        ld_last = last;
        if (to_b) ld_valid_b = 1'b1;
        else      ld_valid_a = 1'b1;
        @(posedge clk);
        while (!(to_b ? ld_ready_b : ld_ready_a) && budget < 20) begin
            budget = budget + 1;
            @(posedge clk);
        end
        #1;
        if (budget >= 20) begin
            n_checks = n_checks + 1;
            $display("FAIL handshake_timeout: actual=ld_ready low required=ld_ready high");
        end
        ld_valid_a = 1'b0;
        ld_valid_b = 1'b0;
        ld_last    = 1'b0;
    endtask

    task automatic send_word(input bit to_b, input logic [31:0] w, input logic last);
        send_byte(to_b, w[31:24], 1'b0);
        send_byte(to_b, w[23:16], 1'b0);
        send_byte(to_b, w[15:8],  1'b0);
        send_byte(to_b, w[7:0],   last);
    endtask

    initial begin
        logic [31:0] b_words [5];
        b_words = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F, 32'h20212223};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk(S_CRST_A,  32'h1, "reset_core_rst");
        chk(S_READY_A, 32'h1, "reset_ld_ready");
        chk(S_DONE_A,  32'h0, "reset_ld_done");
        chk(S_ERR_A,   32'h0, "reset_ld_err");
        chk(S_WORDS_A, 32'h0, "reset_ld_words");
        chk(S_STATE_A, 32'h0, "reset_state_load");
        fetch(S_INST_A, 1'b1, 32'h0, 32'h0, "reset_inst_nop");

        // Seed mem[2] so a later shorter image can expose retained contents.
        send_word(1'b0, 32'h11111111, 1'b0);
        send_word(1'b0, 32'h22222222, 1'b0);
        send_word(1'b0, 32'hDEADBEEF, 1'b1);
        chk(S_WORDS_A, 32'd3, "seed_ld_words");

        do_reset();
        send_word(1'b0, 32'h34010005, 1'b0);
        chk(S_DONE_A, 32'h0, "midload_ld_done");
        send_word(1'b0, 32'h34020007, 1'b1);
        chk(S_DONE_A,  32'h1, "prog_ld_done");
        chk(S_CRST_A,  32'h0, "prog_core_rst");
        chk(S_READY_A, 32'h0, "prog_ld_ready");
        chk(S_WORDS_A, 32'd2, "prog_ld_words");
        fetch(S_INST_A, 1'b1, 32'h0000_0000, 32'h34010005, "prog_fetch0");
        fetch(S_INST_A, 1'b1, 32'h0000_0004, 32'h34020007, "prog_fetch4");
        fetch(S_INST_A, 1'b1, 32'h0000_0008, 32'hDEADBEEF, "prog_fetch8_retained");
        fetch(S_INST_A, 1'b1, 32'h0000_0002, 32'h0, "misaligned_nop");
        fetch(S_INST_A, 1'b1, 32'h0001_0000, 32'h0, "out_of_range_nop");
        fetch(S_INST_A, 1'b1, 32'h0000_1000, 32'h0, "just_past_end_nop");
        fetch(S_INST_A, 1'b0, 32'h0000_0000, 32'h0, "ce_low_nop");

        do_reset();
        send_word(1'b0, 32'hAABBCCDD, 1'b0);
        send_byte(1'b0, 8'h11, 1'b0);
        send_byte(1'b0, 8'h22, 1'b1);
        chk(S_WORDS_A, 32'd2, "pad_ld_words");
        fetch(S_INST_A, 1'b1, 32'h0, 32'hAABBCCDD, "pad_fetch0");
        fetch(S_INST_A, 1'b1, 32'h4, 32'h11220000, "pad_fetch4");

        // Reset mid-word must discard the partial bytes.
        do_reset();
        send_byte(1'b0, 8'h99, 1'b0);
        send_byte(1'b0, 8'h88, 1'b0);
        send_byte(1'b0, 8'h77, 1'b0);
        fetch(S_INST_A, 1'b1, 32'h0, 32'h0, "load_phase_fetch_nop");
        do_reset();
        chk(S_WORDS_A, 32'd0, "restart_ld_words_zero");
        send_word(1'b0, 32'h01020304, 1'b1);
        chk(S_WORDS_A, 32'd1, "restart_ld_words");
        chk(S_DONE_A,  32'h1, "restart_ld_done");
        fetch(S_INST_A, 1'b1, 32'h0, 32'h01020304, "restart_fetch0");
        fetch(S_INST_A, 1'b1, 32'h4, 32'h11220000, "restart_fetch4_retained");

`ifdef INST_ROM_CHECKSUM_EN
        do_reset();
        chk(S_CSUM_A, 32'h0, "csum_reset");
        send_word(1'b0, 32'hFFFFFFFF, 1'b0);
        send_word(1'b0, 32'h00000002, 1'b1);
        chk(S_CSUM_A, 32'h00000001, "csum_wrap");
        do_reset();
        send_word(1'b0, 32'h00000010, 1'b0);
        send_byte(1'b0, 8'h01, 1'b1);
        chk(S_CSUM_A, 32'h01000010, "csum_padded");
`endif

        // Four-word instance: fifth word overflows.
        do_reset();
        for (int i = 0; i < 4; i++) send_word(1'b1, b_words[i], 1'b0);
        chk(S_WORDS_B, 32'd4, "full_ld_words");
        chk(S_ERR_B,   32'h0, "full_no_err");
        send_word(1'b1, b_words[4], 1'b1);
        chk(S_ERR_B,   32'h1, "ovf_ld_err");
        chk(S_WORDS_B, 32'd4, "ovf_ld_words_sat");
        chk(S_DONE_B,  32'h1, "ovf_ld_done");
        for (int i = 0; i < 4; i++)
            fetch(S_INST_B, 1'b1, 32'(i * 4), b_words[i], "ovf_mem_intact");
        fetch(S_INST_B, 1'b1, 32'h10, 32'h0, "small_out_of_range_nop");
        do_reset();
        chk(S_ERR_B, 32'h0, "ovf_err_cleared");

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks = n_checks + 1;
            $display("FAIL scoreboard_drain: actual=%0d left required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
